// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO among N_CLIENTS push/pop requesters.
// Optional `LIFO_ARB_PRIO_EN`: client 0 gets strict priority over the round-robin clients.
module lifo_arbiter #(
    parameter int unsigned N_CLIENTS  = 4,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned AWIDTH     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic [N_CLIENTS-1:0]        push_valid_i,
    input  logic [N_CLIENTS*DWIDTH-1:0] push_data_i,
    output logic [N_CLIENTS-1:0]        push_ready_o,
    input  logic [N_CLIENTS-1:0]        pop_valid_i,
    output logic [N_CLIENTS-1:0]        pop_ready_o,
    output logic [N_CLIENTS-1:0]        pop_rsp_valid_o,
    output logic [DWIDTH-1:0]           pop_rsp_data_o,
    output logic                        lifo_wrreq_o,
    output logic [DWIDTH-1:0]           lifo_data_o,
    output logic                        lifo_rdreq_o,
    input  logic [DWIDTH-1:0]           lifo_q_i,
    output logic [AWIDTH:0]             usedw_o
);

    localparam int unsigned     PtrW     = $clog2(N_CLIENTS);
    localparam logic [AWIDTH:0] Capacity = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] OccOne   = (AWIDTH + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [PtrW-1:0] LastIdx  = PtrW'(N_CLIENTS - 1);

    logic [AWIDTH:0]                     occ_q, occ_d;
    logic [PtrW-1:0]                     rr_q, rr_d;
    logic                                wr_q, rd_q;
    logic [DWIDTH-1:0]                   wdata_q;
    logic [RD_LATENCY:0][N_CLIENTS-1:0]  tag_q;
    logic [N_CLIENTS-1:0]                rsp_valid_q;
    logic [DWIDTH-1:0]                   rsp_data_q;

    logic                 empty, full;
    logic [N_CLIENTS-1:0] pop_req, push_req, req, gnt_vec;
    logic                 gnt_any, gnt_push, gnt_pop;
    logic [PtrW-1:0]      gnt_idx;
    logic [DWIDTH-1:0]    gnt_data;

    // A pending pop masks the same client's push so the push retries later.
    always_comb begin
        empty    = (occ_q == '0);
        full     = (occ_q == Capacity);
        pop_req  = pop_valid_i & {N_CLIENTS{!empty}};
        push_req = push_valid_i & ~pop_req & {N_CLIENTS{!full}};
        req      = pop_req | push_req;
    end

    always_comb begin
        int              idx;
        logic [PtrW-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
`ifdef LIFO_ARB_PRIO_EN
        if (req[0]) gnt_any = 1'b1;
`endif
        for (int k = 0; k < int'(N_CLIENTS); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(N_CLIENTS)) idx = idx - int'(N_CLIENTS);
            cand = PtrW'(idx);
`ifdef LIFO_ARB_PRIO_EN
            if (!gnt_any && req[cand] && cand != '0) begin
`else
            if (!gnt_any && req[cand]) begin
`endif
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_any && !arst_i) gnt_vec[gnt_idx] = 1'b1;
        push_ready_o = gnt_vec & push_req;
        pop_ready_o  = gnt_vec & pop_req;
        gnt_push     = |push_ready_o;
        gnt_pop      = |pop_ready_o;
        gnt_data     = push_data_i[gnt_idx*DWIDTH +: DWIDTH];

        occ_d = occ_q;
        if (gnt_push)     occ_d = occ_q + OccOne;
        else if (gnt_pop) occ_d = occ_q - OccOne;

        rr_d = rr_q;
`ifdef LIFO_ARB_PRIO_EN
        if ((gnt_push || gnt_pop) && gnt_idx != '0)
`else
        if (gnt_push || gnt_pop)
`endif
            rr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + PtrOne;
    end

    // tag_q[k] carries the popping client's one-hot; the last stage lines up with lifo_q_i.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            occ_q       <= '0;
            rr_q        <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            wdata_q     <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            occ_q       <= occ_d;
            rr_q        <= rr_d;
            wr_q        <= gnt_push;
            rd_q        <= gnt_pop;
            if (gnt_push) wdata_q <= gnt_data;
            tag_q       <= {tag_q[RD_LATENCY-1:0], pop_ready_o};
            rsp_valid_q <= tag_q[RD_LATENCY];
            if (|tag_q[RD_LATENCY]) rsp_data_q <= lifo_q_i;
        end
    end

    assign lifo_wrreq_o    = wr_q;
    assign lifo_rdreq_o    = rd_q;
    assign lifo_data_o     = wdata_q;
    assign pop_rsp_valid_o = rsp_valid_q;
    assign pop_rsp_data_o  = rsp_data_q;
    assign usedw_o         = occ_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: behavioural LIFO, queue-based scoreboard, random traffic.
module tb_lifo_arbiter;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 2;
    localparam int RDL = 1;
    localparam int CAP = 4;

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [N-1:0]    push_valid = '0, pop_valid = '0;
    logic [N*DW-1:0] push_data = '0;
    logic [N-1:0]    push_ready, pop_ready, rsp_valid;
    logic [DW-1:0]   rsp_data, lifo_data, lifo_q;
    logic            lifo_wr, lifo_rd;
    logic [AW:0]     usedw;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lifo_arbiter #(.N_CLIENTS(N), .DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clk_i(clk), .arst_i(arst),
        .push_valid_i(push_valid), .push_data_i(push_data), .push_ready_o(push_ready),
        .pop_valid_i(pop_valid), .pop_ready_o(pop_ready),
        .pop_rsp_valid_o(rsp_valid), .pop_rsp_data_o(rsp_data),
        .lifo_wrreq_o(lifo_wr), .lifo_data_o(lifo_data), .lifo_rdreq_o(lifo_rd),
        .lifo_q_i(lifo_q), .usedw_o(usedw)
    );

    // Behavioural LIFO with one cycle read latency.
    logic [DW-1:0] mem [CAP];
    int sp;
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            sp     <= 0;
            lifo_q <= '0;
        end else if (lifo_wr && sp < CAP) begin
            mem[sp] <= lifo_data;
            sp      <= sp + 1;
        end else if (lifo_rd && sp > 0) begin
            lifo_q <= mem[sp-1];
            sp     <= sp - 1;
        end
    end

    // Scoreboard: stack contents as a queue, responses scheduled by due cycle.
    typedef struct {int due; int client; logic [DW-1:0] data;} rsp_t;
    logic [DW-1:0] m_stack[$];
    rsp_t          m_pend[$];
    int            m_rr, cyc;
    logic          e_wr, e_rd;
    logic [DW-1:0] e_wdata, e_rsp_data;
    logic [N-1:0]  e_rsp_valid;

    function automatic int model_grant(output bit is_pop);
        int g;
        bit nz, nf;
        g  = -1;
        nz = m_stack.size() != 0;
        nf = m_stack.size() != CAP;
`ifdef LIFO_ARB_PRIO_EN
        if ((pop_valid[0] && nz) || (push_valid[0] && nf)) g = 0;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
`ifdef LIFO_ARB_PRIO_EN
            if (i == 0) continue;
`endif
            if (g < 0 && ((pop_valid[i] && nz) || (push_valid[i] && nf))) g = i;
        end
        is_pop = (g >= 0) && pop_valid[g] && nz;
        return g;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_stack.delete();
            m_pend.delete();
            m_rr = 0; cyc = 0;
            e_wr = 0; e_rd = 0; e_wdata = '0; e_rsp_data = '0; e_rsp_valid = '0;
        end else begin
            int   g;
            bit   p;
            rsp_t r;
            g   = model_grant(p);
            cyc = cyc + 1;
            e_wr = 0;
            e_rd = 0;
            if (g >= 0) begin
                if (p) begin
                    r.due    = cyc + 1 + RDL;
                    r.client = g;
                    r.data   = m_stack.pop_back();
                    m_pend.push_back(r);
                    e_rd = 1;
                end else begin
                    m_stack.push_back(push_data[g*DW +: DW]);
                    e_wr    = 1;
                    e_wdata = push_data[g*DW +: DW];
                end
`ifdef LIFO_ARB_PRIO_EN
                if (g != 0) m_rr = (g + 1) % N;
`else
                m_rr = (g + 1) % N;
`endif
            end
            e_rsp_valid = '0;
            if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
                r           = m_pend.pop_front();
                e_rsp_valid = N'(1) << r.client;
                e_rsp_data  = r.data;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        push_valid = '0; pop_valid = '0; push_data = '0;
        arst = 1'b1;
        next_cycle();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        push_valid = '1; pop_valid = N'($urandom); push_data = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({push_ready, pop_ready} !== '0) begin
                failures++;
                $display("FAIL reset_ready: got push=%b pop=%b want 0", push_ready, pop_ready);
            end
            checks++;
            if ({lifo_wr, lifo_rd, lifo_data, usedw} !== '0) begin
                failures++;
                $display("FAIL reset_lifo: got wr=%b rd=%b data=%h usedw=%0d want 0",
                         lifo_wr, lifo_rd, lifo_data, usedw);
            end
            checks++;
            if ({rsp_valid, rsp_data} !== '0) begin
                failures++;
                $display("FAIL reset_rsp: got valid=%b data=%h want 0", rsp_valid, rsp_data);
            end
            next_cycle();
        end
        apply_reset();
    endtask

    task automatic test_push_pop_seq();
        logic [DW-1:0] vals [3];
        logic [N-1:0]  exp_v;
        vals = '{16'h00A1, 16'h00A2, 16'h00A3};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            push_valid = (k < 3) ? 4'b0010 : 4'b0000;
            push_data  = '0;
            if (k < 3) push_data[DW +: DW] = vals[k];
            @(negedge clk);
            checks++;
            if (push_ready !== push_valid) begin
                failures++;
                $display("FAIL seq_push_ready[%0d]: got %b want %b", k, push_ready, push_valid);
            end
            if (k > 0) begin
                checks++;
                if (lifo_wr !== 1'b1 || lifo_data !== vals[k-1]) begin
                    failures++;
                    $display("FAIL seq_wrreq[%0d]: got wr=%b data=%h want 1 %h",
                             k, lifo_wr, lifo_data, vals[k-1]);
                end
            end
            next_cycle();
        end
        for (int k = 0; k < 7; k++) begin
            pop_valid = (k < 3) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (usedw !== 3'd3 || lifo_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_full3: got usedw=%0d wr=%b want 3 0", usedw, lifo_wr);
                end
            end
            if (k < 3) begin
                checks++;
                if (pop_ready !== 4'b0100) begin
                    failures++;
                    $display("FAIL seq_pop_ready[%0d]: got %b want 0100", k, pop_ready);
                end
            end
            exp_v = (k >= 3 && k < 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (rsp_valid !== exp_v || (exp_v != 0 && rsp_data !== vals[5-k])) begin
                failures++;
                $display("FAIL seq_rsp[%0d]: got valid=%b data=%h want %b %h",
                         k, rsp_valid, rsp_data, exp_v, (k >= 3 && k < 6) ? vals[5-k] : 16'h0);
            end
            if (k == 6) begin
                checks++;
                if (usedw !== 3'd0) begin
                    failures++;
                    $display("FAIL seq_empty: got usedw=%0d want 0", usedw);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fill();
        logic [N-1:0] exp;
        apply_reset();
        push_valid = '1;
        for (int c = 0; c < N; c++) push_data[c*DW +: DW] = 16'h00B0 + 16'(c);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = (k < 4) ? (N'(1) << k) : '0;
            checks++;
            if (push_ready !== exp || (k >= 4 && usedw !== 3'd4)) begin
                failures++;
                $display("FAIL fill[%0d]: got ready=%b usedw=%0d want %b %0d",
                         k, push_ready, usedw, exp, (k >= 4) ? 4 : k);
            end
            next_cycle();
        end
        pop_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (pop_ready !== 4'b0010 || push_ready !== 4'b0000) begin
            failures++;
            $display("FAIL fill_pop: got pop=%b push=%b want 0010 0000", pop_ready, push_ready);
        end
        next_cycle();
        pop_valid = '0;
        @(negedge clk);
        checks++;
        if (push_ready !== 4'b0100) begin
            failures++;
            $display("FAIL fill_refill: got push=%b want 0100", push_ready);
        end
        next_cycle();
    endtask

    task automatic test_pop_push_same();
        apply_reset();
        push_valid = 4'b0001; pop_valid = 4'b0001; push_data = '0; push_data[0 +: DW] = 16'h005C;
        @(negedge clk);
        checks++;
        if (push_ready !== 4'b0001 || pop_ready !== 4'b0000) begin
            failures++;
            $display("FAIL same_first: got push=%b pop=%b want 0001 0000", push_ready, pop_ready);
        end
        next_cycle();
        push_valid = '0;
        @(negedge clk);
        checks++;
        if (pop_ready !== 4'b0001 || lifo_wr !== 1'b1) begin
            failures++;
            $display("FAIL same_pop: got pop=%b wr=%b want 0001 1", pop_ready, lifo_wr);
        end
        next_cycle();
        pop_valid = '0;
        @(negedge clk);
        checks++;
        if (lifo_rd !== 1'b1 || lifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL same_rdreq: got rd=%b wr=%b want 1 0", lifo_rd, lifo_wr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL same_early: got valid=%b want 0000", rsp_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h005C) begin
            failures++;
            $display("FAIL same_rsp: got valid=%b data=%h want 0001 005c", rsp_valid, rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_rr_pop();
        apply_reset();
        push_valid = 4'b0010; push_data = '0; push_data[1*DW +: DW] = 16'h00C1;
        next_cycle();
        push_valid = 4'b0100; push_data[2*DW +: DW] = 16'h00C2;
        next_cycle();
        push_valid = '0; pop_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (pop_ready !== 4'b1000 || usedw !== 3'd2) begin
            failures++;
            $display("FAIL rr_first: got pop=%b usedw=%0d want 1000 2", pop_ready, usedw);
        end
        next_cycle();
        pop_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (pop_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rr_second: got pop=%b want 0001", pop_ready);
        end
        next_cycle();
        pop_valid = '0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 16'h00C2) begin
            failures++;
            $display("FAIL rr_rsp3: got valid=%b data=%h want 1000 00c2", rsp_valid, rsp_data);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h00C1) begin
            failures++;
            $display("FAIL rr_rsp0: got valid=%b data=%h want 0001 00c1", rsp_valid, rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push_valid = 4'b0001; push_data = '0; push_data[0 +: DW] = 16'h00D0;
        next_cycle();
        push_data[0 +: DW] = 16'h00D1;
        next_cycle();
        push_valid = '0; pop_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (pop_ready !== 4'b1000) begin
            failures++;
            $display("FAIL mid_grant: got pop=%b want 1000", pop_ready);
        end
        next_cycle();
        arst = 1'b1; pop_valid = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({push_ready, pop_ready, rsp_valid, rsp_data, lifo_wr, lifo_rd, lifo_data,
                 usedw} !== '0) begin
                failures++;
                $display("FAIL mid_reset_outs[%0d]: got rd=%b rsp=%b usedw=%0d want all 0",
                         k, lifo_rd, rsp_valid, usedw);
            end
            next_cycle();
        end
        arst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== '0 || usedw !== '0) begin
                failures++;
                $display("FAIL mid_after[%0d]: got rsp=%b usedw=%0d want 0 0", k, rsp_valid, usedw);
            end
            next_cycle();
        end
    endtask

`ifdef LIFO_ARB_PRIO_EN
    task automatic test_prio();
        logic [N-1:0] exp;
        apply_reset();
        push_valid = 4'b0011; push_data = {$urandom, $urandom};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = (k < CAP) ? 4'b0001 : 4'b0000;
            checks++;
            if (push_ready !== exp) begin
                failures++;
                $display("FAIL prio[%0d]: got %b want %b", k, push_ready, exp);
            end
            next_cycle();
        end
    endtask
`endif

    task automatic test_random();
        int           g;
        bit           p;
        logic [N-1:0] exp_push, exp_pop;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            push_valid = N'($urandom);
            pop_valid  = ((i / 40) % 2 == 0) ? N'($urandom & $urandom & $urandom) : N'($urandom);
            push_data  = {$urandom, $urandom};
            @(negedge clk);
            g = model_grant(p);
            exp_push = (g >= 0 && !p) ? (N'(1) << g) : '0;
            exp_pop  = (g >= 0 && p) ? (N'(1) << g) : '0;
            checks++;
            if (push_ready !== exp_push || pop_ready !== exp_pop) begin
                failures++;
                $display("FAIL rand_grant[%0d]: got push=%b pop=%b want %b %b",
                         i, push_ready, pop_ready, exp_push, exp_pop);
            end
            checks++;
            if (lifo_wr !== e_wr || lifo_rd !== e_rd || lifo_data !== e_wdata) begin
                failures++;
                $display("FAIL rand_lifo[%0d]: got wr=%b rd=%b data=%h want %b %b %h",
                         i, lifo_wr, lifo_rd, lifo_data, e_wr, e_rd, e_wdata);
            end
            checks++;
            if (usedw !== (AW + 1)'(m_stack.size())) begin
                failures++;
                $display("FAIL rand_usedw[%0d]: got %0d want %0d", i, usedw, m_stack.size());
            end
            checks++;
            if (rsp_valid !== e_rsp_valid || rsp_data !== e_rsp_data) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got valid=%b data=%h want %b %h",
                         i, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
            end
            checks++;
            if (lifo_wr && lifo_rd) begin
                failures++;
                $display("FAIL rand_strobes[%0d]: got wr=1 rd=1 want not both", i);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_push_pop_seq();
        test_pop_push_same();
        test_reset_mid();
`ifdef LIFO_ARB_PRIO_EN
        test_prio();
`else
        test_fill();
        test_rr_pop();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
Shares a single lifo instance between N_CLIENTS requesters. Each client can push and pop through its own valid/ready ports. Per cycle, the block round-robin arbitrates one LIFO operation, drives the LIFO write/read strobes from registers, and routes each popped word back to the client that requested it. It tracks occupancy internally, so grants never overflow or underflow the stack.

Parameters:
N_CLIENTS, 4, number of requesters (2..16)
DWIDTH, 16, data width; must match the LIFO
AWIDTH, 8, LIFO address width; capacity = 2**AWIDTH words
RD_LATENCY, 1, cycles from lifo_rdreq_o high to lifo_q_i valid (1..4)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous active-high reset
push_valid_i  in  N_CLIENTS  per-client push request
push_data_i  in  N_CLIENTS*DWIDTH  push data; client i occupies bits [i*DWIDTH +: DWIDTH]
push_ready_o  out  N_CLIENTS  push grant (one-hot or zero)
pop_valid_i  in  N_CLIENTS  per-client pop request
pop_ready_o  out  N_CLIENTS  pop grant (one-hot or zero)
pop_rsp_valid_o  out  N_CLIENTS  one-hot pulse: popped word for client i
pop_rsp_data_o  out  DWIDTH  popped word
lifo_wrreq_o  out  1  to LIFO wrreq_i
lifo_data_o  out  DWIDTH  to LIFO data_i
lifo_rdreq_o  out  1  to LIFO rdreq_i
lifo_q_i  in  DWIDTH  from LIFO q_o
usedw_o  out  AWIDTH+1  internal occupancy count, 0..2**AWIDTH

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - all outputs 0; rr pointer = 0; occupancy = 0; response pipeline cleared.
  - The LIFO must be reset concurrently.
- Per-client request selection:
  - Client i requests pop if pop_valid_i[i] and occupancy != 0.
  - Otherwise it requests push if push_valid_i[i] and occupancy != 2**AWIDTH.
  - If both valid: pop wins; the push stays pending.
- Arbitration:
  - Round-robin, starting search at the rr pointer.
  - Exactly one grant per cycle at most; grants are combinational from the current-cycle inputs.
  - On a grant to client g, the pointer becomes (g+1) mod N_CLIENTS. With no grant, the pointer holds.
- Transfer: occurs in cycle T when valid && ready for the granted client.
- Push at T:
  - lifo_wrreq_o = 1 and lifo_data_o = client data at T+1.
  - Occupancy increments at the T clock edge.
- Pop at T:
  - lifo_rdreq_o = 1 at T+1; occupancy decrements at the T edge.
  - The client index enters a tag shift pipeline of depth 1+RD_LATENCY.
  - At T+2+RD_LATENCY: pop_rsp_data_o = registered lifo_q_i, and pop_rsp_valid_o has the tag bit set for one cycle.
  - pop_rsp_data_o holds its value between pulses.
- LIFO strobes: lifo_wrreq_o and lifo_rdreq_o are never high in the same cycle.
- Back-to-back: a new op may be granted every cycle; occupancy is updated at grant time, so no bubbles are needed.
  - Push then pop on consecutive cycles returns the just-pushed word.
- Full (occupancy = 2**AWIDTH): all push_ready_o = 0; pops are still granted.
- Empty (occupancy = 0): all pop_ready_o = 0; pushes are still granted.
- Occupancy arithmetic: AWIDTH+1 bits; never wraps.
- Reset mid-operation: in-flight responses are dropped; no pop_rsp_valid_o pulse after reset.
- Clients must hold valid and data until ready is seen. Dropping valid without ready is legal and cancels the request.

Optional Feature:
LIFO_ARB_PRIO_EN:
- Defined: client 0 has strict priority over all others. Clients 1..N-1 round-robin among themselves when client 0 has no eligible request. The rr pointer ignores client 0 grants.
- Undefined: pure round-robin over all clients, as above.

Test Plan:
- N=4, AWIDTH=2. Client 1 pushes 0xA1, 0xA2, 0xA3 on consecutive cycles -> lifo_wrreq_o high 3 cycles; usedw_o = 3.
- Then client 2 pops 3 times -> pop_rsp_valid_o = 4'b0100 with data 0xA3, 0xA2, 0xA1, first at 3 cycles after the pop handshake (RD_LATENCY=1); usedw_o = 0.
- All 4 clients assert push continuously from empty -> grants in order 0,1,2,3. After 4 pushes usedw_o = 4 and all push_ready_o = 0 until a pop occurs.
- From empty, client 0 asserts pop and push together -> pop not granted, push granted. Next cycle the pop is granted and returns the same word to client 0.
- Clients 0 and 3 both pop with usedw_o = 2, pointer at 3 -> client 3 is served first. Responses are tagged 4'b1000 then 4'b0001, carrying the top and second words respectively.
- Assert arst_i one cycle after a pop grant -> no pop_rsp_valid_o pulse; usedw_o = 0; all outputs 0 during reset.
- With LIFO_ARB_PRIO_EN, clients 0 and 1 push continuously -> client 0 is granted every cycle until full.
